// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: S-box table, Rcon helpers, word rotation,
// FSM state encoding and the legal key-length check.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_FIN
  } state_e;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Cyclic left rotation by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic bit nk_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: independent S-box substitution of each byte of a 32-bit word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o[31:24] = SBOX[word_i[31:24]];
  assign word_o[23:16] = SBOX[word_i[23:16]];
  assign word_o[15:8]  = SBOX[word_i[15:8]];
  assign word_o[7:0]   = SBOX[word_i[7:0]];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128/192/256 key schedule: one word per clock into an NW-word
// store, with any round key readable combinationally once the schedule is ready.
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*NK-1:0]  key_in,
  output logic              busy,
  output logic              done,
  output logic              ready,
  input  logic [3:0]        rk_idx,
  output logic [127:0]      rk_out,
  output logic              word_valid,
  output logic [31:0]       word_out,
  output logic [5:0]        word_idx
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (!nk_legal(NK)) begin : g_bad_nk
    $error("aes_key_expand_seq: NK must be 4, 6 or 8");
  end

  state_e      state_q;
  logic [31:0] w_q [NW];
  logic [5:0]  i_q;
  logic [2:0]  pos_q;   // i_q mod NK, tracked incrementally to avoid a divider
  logic [7:0]  rcon_q;
  logic        busy_q, done_q, ready_q, word_valid_q;
  logic [31:0] word_out_q;
  logic [5:0]  word_idx_q;

  logic [31:0] w_prev, w_old, sub_in, sub_out, word_d;

  assign w_prev = w_q[i_q - 6'd1];
  assign w_old  = w_q[i_q - 6'(NK)];
  assign sub_in = (pos_q == 3'd0) ? rot_word(w_prev) : w_prev;

  aes_subword u_subword (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    word_d = w_old ^ w_prev;
    if (pos_q == 3'd0) begin
      word_d = w_old ^ sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && pos_q == 3'd4) begin
      word_d = w_old ^ sub_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      i_q          <= '0;
      pos_q        <= '0;
      rcon_q       <= RCON_INIT;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
      word_idx_q   <= '0;
      // NOTE: the schedule store is reset so no stale key material survives a
      // reset; this costs a reset net on every storage flop.
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
    end else begin
      done_q       <= 1'b0;
      word_valid_q <= 1'b0;
      word_out_q   <= '0;
      word_idx_q   <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int j = 0; j < NK; j++) w_q[j] <= key_in[32*(NK-1-j) +: 32];
            i_q     <= 6'(NK);
            pos_q   <= '0;
            rcon_q  <= RCON_INIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          w_q[i_q]     <= word_d;
          word_valid_q <= 1'b1;
          word_out_q   <= word_d;
          word_idx_q   <= i_q;
          i_q          <= i_q + 6'd1;
          pos_q        <= (pos_q == 3'(NK - 1)) ? 3'd0 : pos_q + 3'd1;
          if (pos_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == 6'(NW - 1)) state_q <= ST_FIN;
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [5:0] rk_base;

  always_comb begin
    rk_base = '0;
    rk_out  = '0;
    if (ready_q && int'(rk_idx) <= NR) begin
      rk_base = {rk_idx, 2'b00};
      rk_out  = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ready      = ready_q;
  assign word_valid = word_valid_q;
  assign word_out   = word_out_q;
  assign word_idx   = word_idx_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Runs AES-128/192/256 schedule engines side by side against a FIPS-197 style
// model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_key_expand_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [3:0]   rk_idx;
  logic [127:0] k4;
  logic [191:0] k6;
  logic [255:0] k8;

  logic         busy [3];
  logic         done [3];
  logic         ready [3];
  logic         wv [3];
  logic [31:0]  wo [3];
  logic [5:0]   wi [3];
  logic [127:0] rko [3];

  int checks   = 0;
  int failures = 0;

  logic [7:0]  sbox_m [256];
  logic [31:0] ref_w [3][60];
  int          done_cyc [3];

  aes_key_expand_seq #(.NK(4)) u_nk4 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(k4),
    .busy(busy[0]), .done(done[0]), .ready(ready[0]), .rk_idx(rk_idx), .rk_out(rko[0]),
    .word_valid(wv[0]), .word_out(wo[0]), .word_idx(wi[0])
  );
  aes_key_expand_seq #(.NK(6)) u_nk6 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(k6),
    .busy(busy[1]), .done(done[1]), .ready(ready[1]), .rk_idx(rk_idx), .rk_out(rko[1]),
    .word_valid(wv[1]), .word_out(wo[1]), .word_idx(wi[1])
  );
  aes_key_expand_seq #(.NK(8)) u_nk8 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(k8),
    .busy(busy[2]), .done(done[2]), .ready(ready[2]), .rk_idx(rk_idx), .rk_out(rko[2]),
    .word_valid(wv[2]), .word_out(wo[2]), .word_idx(wi[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  // Rcon for round j is x^(j-1) in GF(2^8).
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < j; k++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  task automatic model(input int s, input int nk, input logic [255:0] key);
    logic [31:0] t;
    for (int j = 0; j < nk; j++) ref_w[s][j] = key[32*(nk-1-j) +: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = ref_w[s][i-1];
      if (i % nk == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4)
        t = sub_word(t);
      ref_w[s][i] = ref_w[s][i-nk] ^ t;
    end
  endtask

  task automatic check_all_zero(input string when);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("%s_busy_nk%0d", when, 4 + 2 * s), 128'(busy[s]), 128'(0));
      check($sformatf("%s_done_nk%0d", when, 4 + 2 * s), 128'(done[s]), 128'(0));
      check($sformatf("%s_ready_nk%0d", when, 4 + 2 * s), 128'(ready[s]), 128'(0));
      check($sformatf("%s_wvalid_nk%0d", when, 4 + 2 * s), 128'(wv[s]), 128'(0));
      check($sformatf("%s_wout_nk%0d", when, 4 + 2 * s), 128'(wo[s]), 128'(0));
      check($sformatf("%s_widx_nk%0d", when, 4 + 2 * s), 128'(wi[s]), 128'(0));
      check($sformatf("%s_rk_nk%0d", when, 4 + 2 * s), rko[s], 128'(0));
    end
  endtask

  // Starts all three engines together and checks every output each cycle.
  // With junk=1, start is re-pulsed with fresh keys while the engines are busy.
  task automatic start_and_check(input bit junk);
    int nk;
    int last;
    model(0, 4, {128'h0, k4});
    model(1, 6, {64'h0, k6});
    model(2, 8, k8);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      done_cyc[s] = -1;
      check($sformatf("c0_busy_nk%0d", 4 + 2 * s), 128'(busy[s]), 128'(1));
      check($sformatf("c0_ready_nk%0d", 4 + 2 * s), 128'(ready[s]), 128'(0));
      check($sformatf("c0_wvalid_nk%0d", 4 + 2 * s), 128'(wv[s]), 128'(0));
    end
    for (int c = 1; c <= 56; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        nk   = 4 + 2 * s;
        last = 4 * (nk + 7) - nk;
        if (done[s] === 1'b1) done_cyc[s] = c;
        check($sformatf("busy_nk%0d_c%0d", nk, c), 128'(busy[s]), 128'(c <= last));
        check($sformatf("done_nk%0d_c%0d", nk, c), 128'(done[s]), 128'(c == last + 1));
        check($sformatf("ready_nk%0d_c%0d", nk, c), 128'(ready[s]), 128'(c >= last + 1));
        check($sformatf("wvalid_nk%0d_c%0d", nk, c), 128'(wv[s]), 128'(c <= last));
        if (c <= last) begin
          check($sformatf("wout_nk%0d_c%0d", nk, c), 128'(wo[s]), 128'(ref_w[s][nk + c - 1]));
          check($sformatf("widx_nk%0d_c%0d", nk, c), 128'(wi[s]), 128'(nk + c - 1));
        end else begin
          check($sformatf("wout_idle_nk%0d_c%0d", nk, c), 128'(wo[s]), 128'(0));
          check($sformatf("widx_idle_nk%0d_c%0d", nk, c), 128'(wi[s]), 128'(0));
        end
      end
      start = 1'b0;
      if (junk && c < 40 && $urandom_range(1, 0) == 1) begin
        start = 1'b1;
        k4 = {$urandom, $urandom, $urandom, $urandom};
        k6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        k8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
    end
    start = 1'b0;
  endtask

  task automatic check_round_keys();
    logic [127:0] exp;
    for (int idx = 0; idx < 16; idx++) begin
      rk_idx = 4'(idx);
      #1;
      for (int s = 0; s < 3; s++) begin
        exp = '0;
        if (idx <= 4 + 2 * s + 6)
          exp = {ref_w[s][4*idx], ref_w[s][4*idx+1], ref_w[s][4*idx+2], ref_w[s][4*idx+3]};
        check($sformatf("rk%0d_nk%0d", idx, 4 + 2 * s), rko[s], exp);
      end
    end
  endtask

  task automatic random_keys();
    k4 = {$urandom, $urandom, $urandom, $urandom};
    k6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    k8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    rk_idx = 4'd0;
    k4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    k8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    build_sbox();

    // Reset state, including rk_out before any schedule exists.
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    rk_idx = 4'd15;
    #1;
    for (int s = 0; s < 3; s++) check($sformatf("pre_rk15_nk%0d", 4 + 2 * s), rko[s], 128'(0));

    // Published FIPS-197 vectors.
    start_and_check(1'b0);
    check("done_cycle_nk4", 128'(done_cyc[0]), 128'(41));
    check("done_cycle_nk6", 128'(done_cyc[1]), 128'(47));
    check("done_cycle_nk8", 128'(done_cyc[2]), 128'(53));
    check_round_keys();
    rk_idx = 4'd1;  #1;
    check("nk4_w4", 128'(rko[0][127:96]), 128'(32'ha0fafe17));
    check("nk6_w6", 128'(rko[1][63:32]), 128'(32'hfe0c91f7));
    rk_idx = 4'd10; #1;
    check("nk4_rk10", rko[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rk_idx = 4'd12; #1;
    check("nk6_w51", 128'(rko[1][31:0]), 128'(32'h01002202));
    rk_idx = 4'd2;  #1;
    check("nk8_w8", 128'(rko[2][127:96]), 128'(32'h9ba35411));
    rk_idx = 4'd14; #1;
    check("nk8_w59", 128'(rko[2][31:0]), 128'(32'h706c631e));

    // Restart from ready with random keys while start is hammered mid-expansion.
    random_keys();
    start_and_check(1'b1);
    check_round_keys();

    // Asynchronous reset in the middle of an expansion, then a clean restart.
    random_keys();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    random_keys();
    start_and_check(1'b0);
    check_round_keys();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
